mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, number of 32-bit RAM words.
REQ-002 The block SHALL have parameter AW, default 10, RAM word-address width; AW = clog2(MEM_WORDS).
REQ-003 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m0_valid/m1_valid  in  1  request from port 0 (CPU) / port 1 (loader).
REQ-006 m0_addr/m1_addr  in  32  byte address; bits [1:0] ignored.
REQ-007 m0_wdata/m1_wdata  in  32  write data.
REQ-008 m0_wstrb/m1_wstrb  in  4  byte enables; 0 = read.
REQ-009 m0_ready/m1_ready  out  1  one-cycle completion pulse.
REQ-010 m0_rdata/m1_rdata  out  32  read data, valid while matching ready = 1.
REQ-011 ram_en  out  1  RAM access strobe.
REQ-012 ram_we  out  4  RAM byte write enables.
REQ-013 ram_addr  out  AW  RAM word address.
REQ-014 ram_wdata  out  32  RAM write data.
REQ-015 ram_rdata  in  32  RAM read data, valid the cycle after ram_en.
REQ-016 bus_err  out  1  sticky out-of-range flag.
REQ-017 err_addr  out  32  byte address of first out-of-range access.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and DONE, one transaction in flight at a time.
REQ-019 IDLE, no valid: stay IDLE.
REQ-020 IDLE, any valid: grant one port, latch its addr/wdata/wstrb and port id.
REQ-021 Grant rule: only one valid -> that port; both valid -> port not granted last (round-robin); last-grant register SHALL reset to port 1, so port 0 wins the first tie.
REQ-022 Grant in range (addr[31:2] < MEM_WORDS) -> ACCESS; out of range -> DONE directly.
REQ-023 ACCESS (exactly one cycle): ram_en = 1, ram_addr = latched addr[AW+1:2], ram_wdata = latched wdata, ram_we = latched wstrb; next state DONE.
REQ-024 DONE (exactly one cycle): granted port's ready = 1; next state IDLE.
REQ-025 DONE rdata: read in range -> ram_rdata; write or out-of-range -> 0.
REQ-026 Non-granted port: ready = 0 and rdata = 0 in every cycle.
REQ-027 ram_en, ram_we SHALL be 0 in every state other than ACCESS; ram_addr/ram_wdata hold their last values.
REQ-028 Latency: valid sampled in IDLE at edge N -> ready high in cycle N+2 (in range) or N+1 (out of range); new request accepted no earlier than cycle N+3 / N+2.
REQ-029 Out-of-range access: RAM SHALL NOT be touched; bus_err set; err_addr captured only when bus_err was 0.
REQ-030 Dropping valid after grant: transaction still completes (ready pulse issued); no abort.
REQ-031 Requester SHALL hold addr/wdata/wstrb stable only until grant; the block uses latched copies thereafter.
REQ-032 A port still asserting valid after its ready pulse SHALL be treated as a new request in the next IDLE.

Reset
REQ-033 reset high at an edge: state -> IDLE, last-grant -> port 1, bus_err -> 0, err_addr -> 0, latched registers -> 0.
REQ-034 While reset is high, ram_en, ram_we, m0_ready, m1_ready SHALL be 0 combinationally, suppressing any ACCESS-state write in that cycle.
REQ-035 Reset mid-transaction: transaction discarded, no ready pulse issued for it.

Verification
REQ-036 Read: RAM word 5 = 0xDEADBEEF; m0 read addr 0x14 -> ram_en with ram_addr 5 one cycle later; m0_ready with m0_rdata 0xDEADBEEF the cycle after.
REQ-037 Byte write: m1 writes 0x11223344, wstrb 0b0010, addr 0x20 -> ram_we 0b0010, ram_addr 8, m1_ready with m1_rdata 0.
REQ-038 Contention: both valid continuously from reset -> grants alternate m0, m1, m0, m1; each ready 3 cycles apart.
REQ-039 Out-of-range: m0 read addr 0x1000 (MEM_WORDS=1024) -> no ram_en, m0_ready next cycle with rdata 0, bus_err = 1, err_addr 0x1000; second bad access 0x2000 leaves err_addr 0x1000.
REQ-040 Reset during ACCESS of a write -> ram_we 0 that cycle, no ready pulse, FSM in IDLE and bus_err 0 afterwards.
REQ-041 Drop valid one cycle after grant -> ready still pulses exactly once.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-port round-robin arbiter in front of a single-port synchronous RAM.
//   One transaction is in flight at a time. A granted request either performs
//   one RAM access cycle and then completes, or, if its address is beyond the
//   RAM, completes immediately and raises a sticky bus error.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   m0_* (CPU), m1_* (loader)   valid/addr/wdata/wstrb in, ready/rdata out
//   ram_en/we/addr/wdata        RAM request, ram_rdata returns the cycle after ram_en
//   bus_err, err_addr           sticky out-of-range flag and first offending byte address
//
// state  | meaning
// IDLE   | waiting for a request, arbitrates and latches the winner
// ACCESS | RAM strobed with the latched request
// DONE   | ready pulse to the granted port
module mem_bus_arbiter #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_valid,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    output logic          m0_ready,
    output logic [31:0]   m0_rdata,
    input  logic          m1_valid,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    output logic          m1_ready,
    output logic [31:0]   m1_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    output logic          bus_err,
    output logic [31:0]   err_addr
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;       // port granted most recently
    logic          port_q, port_d;       // port owning the current transaction
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          oor_q, oor_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   err_addr_q, err_addr_d;

    logic          sel;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          req_in_range;

    always_comb begin
        // On a tie the port that did not win last time gets the bus.
        if (m0_valid && m1_valid) begin
            sel = ~last_q;
        end else begin
            sel = m1_valid;
        end
        req_addr     = sel ? m1_addr  : m0_addr;
        req_wdata    = sel ? m1_wdata : m0_wdata;
        req_wstrb    = sel ? m1_wstrb : m0_wstrb;
        req_in_range = ({2'b00, req_addr[31:2]} < 32'(MEM_WORDS));
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        port_d     = port_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        oor_d      = oor_q;
        bus_err_d  = bus_err_q;
        err_addr_d = err_addr_q;
        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    last_d  = sel;
                    port_d  = sel;
                    addr_d  = req_addr[AW+1:2];
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    oor_d   = ~req_in_range;
                    if (req_in_range) begin
                        state_d = ACCESS;
                    end else begin
                        // Skip the RAM entirely; only the first bad address is kept.
                        state_d   = DONE;
                        bus_err_d = 1'b1;
                        if (!bus_err_q) begin
                            err_addr_d = req_addr;
                        end
                    end
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            port_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            oor_q      <= 1'b0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            port_q     <= port_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            oor_q      <= oor_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Strobes are masked by reset so a write caught mid-ACCESS never lands.
    logic        access_act;
    logic        done_act;
    logic [31:0] rd_data;

    assign access_act = (state_q == ACCESS) && !reset;
    assign done_act   = (state_q == DONE) && !reset;
    assign rd_data    = (!oor_q && (wstrb_q == 4'b0000)) ? ram_rdata : 32'h0;

    assign ram_en    = access_act;
    assign ram_we    = access_act ? wstrb_q : 4'b0000;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign m0_ready  = done_act && !port_q;
    assign m1_ready  = done_act && port_q;
    assign m0_rdata  = m0_ready ? rd_data : 32'h0;
    assign m1_rdata  = m1_ready ? rd_data : 32'h0;

    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        m0_valid, m1_valid;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        bus_err;
   logic [31:0] err_addr;

   logic        mem_init;
   logic [31:0] mem [0:1023];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   mem_bus_arbiter #(.MEM_WORDS(1024), .AW(10)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .bus_err(bus_err), .err_addr(err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM model: read data appears the cycle after ram_en.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
         mem[5]    <= 32'hDEADBEEF;
         ram_rdata <= 32'h0;
      end else if (ram_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= mem[ram_addr];
      end
   end

   int cnt;
   int nev;
   int ev_port [4];
   int ev_cyc  [4];
   logic [31:0] ev_data [4];

   initial begin
      reset = 1'b1; mem_init = 1'b1;
      m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
      repeat (2) @(negedge clk);
      chk("rst_ram_en",   ram_en,   1'b0);
      chk("rst_m0_ready", m0_ready, 1'b0);
      chk("rst_m1_ready", m1_ready, 1'b0);
      chk("rst_bus_err",  bus_err,  1'b0);
      chk("rst_err_addr", err_addr, 32'h0);
      reset = 1'b0; mem_init = 1'b0;

      // Read of word 5 by m0; address changed after grant to prove latching
      @(negedge clk);
      m0_valid = 1'b1; m0_addr = 32'h14; m0_wstrb = 4'h0; m0_wdata = 32'h0BADF00D;
      @(negedge clk);
      chk("rd_ram_en",    ram_en,   1'b1);
      chk("rd_ram_addr",  ram_addr, 10'd5);
      chk("rd_ram_we",    ram_we,   4'h0);
      chk("rd_early_rdy", m0_ready, 1'b0);
      m0_valid = 1'b0; m0_addr = 32'hFFFF_FFFC;
      @(negedge clk);
      chk("rd_m0_ready", m0_ready, 1'b1);
      chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
      chk("rd_m1_ready", m1_ready, 1'b0);
      chk("rd_m1_rdata", m1_rdata, 32'h0);
      chk("rd_done_en",  ram_en,   1'b0);
      @(negedge clk);
      chk("rd_idle_rdy", m0_ready, 1'b0);

      // Byte write by m1
      m1_valid = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h11223344; m1_wstrb = 4'b0010;
      @(negedge clk);
      chk("bw_ram_en",    ram_en,    1'b1);
      chk("bw_ram_we",    ram_we,    4'b0010);
      chk("bw_ram_addr",  ram_addr,  10'd8);
      chk("bw_ram_wdata", ram_wdata, 32'h11223344);
      m1_valid = 1'b0;
      @(negedge clk);
      chk("bw_m1_ready", m1_ready, 1'b1);
      chk("bw_m1_rdata", m1_rdata, 32'h0);
      chk("bw_m0_ready", m0_ready, 1'b0);
      chk("bw_mem8",     mem[8],   32'h00003300);
      @(negedge clk);

      // Valid dropped right after grant: exactly one ready pulse
      m0_valid = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hCAFEF00D; m0_wstrb = 4'hF;
      @(negedge clk);
      m0_valid = 1'b0;
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (m0_ready) cnt++;
      end
      chk("drop_rdy_cnt", cnt,     1);
      chk("drop_mem16",   mem[16], 32'hCAFEF00D);
      m0_valid = 1'b1; m0_addr = 32'h40; m0_wstrb = 4'h0;
      @(negedge clk);
      m0_valid = 1'b0;
      @(negedge clk);
      chk("rb_m0_ready", m0_ready, 1'b1);
      chk("rb_m0_rdata", m0_rdata, 32'hCAFEF00D);
      @(negedge clk);

      // Contention from reset: m0, m1, m0, m1, three cycles apart
      reset = 1'b1;
      m0_valid = 1'b1; m0_addr = 32'h14; m0_wstrb = 4'h0;
      m1_valid = 1'b1; m1_addr = 32'h20; m1_wstrb = 4'h0;
      @(negedge clk);
      reset = 1'b0;
      nev = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (m0_ready || m1_ready) begin
            if (nev < 4) begin
               ev_port[nev] = m1_ready ? 1 : 0;
               ev_cyc[nev]  = c;
               ev_data[nev] = m1_ready ? m1_rdata : m0_rdata;
            end
            nev++;
         end
         if (c == 11) begin
            m0_valid = 1'b0; m1_valid = 1'b0;
         end
      end
      chk("rr_events",    nev,       4);
      chk("rr_first_cyc", ev_cyc[0], 2);
      for (int i = 0; i < 4; i++) begin
         chk("rr_port", ev_port[i], i % 2);
         chk("rr_data", ev_data[i], ((i % 2) == 0) ? 32'hDEADBEEF : 32'h00003300);
         if (i > 0) chk("rr_spacing", ev_cyc[i] - ev_cyc[i-1], 3);
      end
      @(negedge clk);

      // Out-of-range accesses
      m0_valid = 1'b1; m0_addr = 32'h1000; m0_wstrb = 4'h0;
      @(negedge clk);
      chk("oor_m0_ready", m0_ready, 1'b1);
      chk("oor_m0_rdata", m0_rdata, 32'h0);
      chk("oor_ram_en",   ram_en,   1'b0);
      chk("oor_bus_err",  bus_err,  1'b1);
      chk("oor_err_addr", err_addr, 32'h1000);
      m0_valid = 1'b0;
      @(negedge clk);
      m1_valid = 1'b1; m1_addr = 32'h2000; m1_wdata = 32'h55555555; m1_wstrb = 4'hF;
      @(negedge clk);
      chk("oor2_m1_ready", m1_ready, 1'b1);
      chk("oor2_ram_en",   ram_en,   1'b0);
      chk("oor2_bus_err",  bus_err,  1'b1);
      chk("oor2_err_addr", err_addr, 32'h1000);
      m1_valid = 1'b0;
      @(negedge clk);

      // Reset during the ACCESS cycle of a write
      m0_valid = 1'b1; m0_addr = 32'h30; m0_wdata = 32'hAAAA5555; m0_wstrb = 4'hF;
      @(negedge clk);
      chk("rsta_ram_we_pre", ram_we, 4'hF);
      reset = 1'b1; m0_valid = 1'b0;
      #1;
      chk("rsta_ram_we", ram_we,   4'h0);
      chk("rsta_ram_en", ram_en,   1'b0);
      chk("rsta_ready",  m0_ready, 1'b0);
      cnt = 0;
      @(negedge clk);
      if (m0_ready) cnt++;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (m0_ready) cnt++;
      end
      chk("rsta_rdy_cnt",  cnt,      0);
      chk("rsta_bus_err",  bus_err,  1'b0);
      chk("rsta_err_addr", err_addr, 32'h0);
      chk("rsta_mem12",    mem[12],  32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
